// File: rtl/output_drain_buffer.sv
// Result drain buffer: circular FIFO between the MAC array and the host,
// with stall back-pressure to the issuer and frame-completion tracking.
module output_drain_buffer #(
    parameter int FIFO_DEPTH         = 16,
    parameter int STALL_SLACK        = 5,
    parameter int DATA_WIDTH         = 32,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [31:0]                   in_x,
    input  logic [31:0]                   in_y,
    input  logic [31:0]                   in_ch,
    output logic                          stall,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [31:0]                   out_x,
    output logic [31:0]                   out_y,
    output logic [31:0]                   out_ch,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int EW = DATA_WIDTH + 96;
    localparam logic [FW-1:0] DEPTH_L     = FW'(FIFO_DEPTH);
    localparam logic [FW-1:0] STALL_TH    = FW'(FIFO_DEPTH - STALL_SLACK);
    localparam logic [FW-1:0] FILL_ONE    = FW'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [31:0]   FRAME_TOTAL =
        32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     pop_count;
    logic            push, pop, drop, clear, full;

    // Handshake: an entry leaves on any cycle where out_valid and out_ready
    // are both high; in_valid is never back-pressured, so a push that finds
    // the FIFO full with no simultaneous pop is dropped and flagged.
    assign full      = (fill_level == DEPTH_L);
    assign out_valid = (fill_level != '0);
    assign pop       = out_valid && out_ready;
    assign clear     = start && (state != DONE);
    assign push      = in_valid && (state == ACTIVE) && !start && (!full || pop);
    assign drop      = in_valid && (state == ACTIVE) && !start && full && !pop;

    assign stall     = (fill_level >= STALL_TH);
    assign done      = (state == DONE);
    assign state_dbg = state;

    assign {out_data, out_x, out_y, out_ch} = mem[rd_ptr];

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = ACTIVE;
            end
            ACTIVE: begin
                if (start)
                    next_state = ACTIVE;
                else if (pop && (pop_count + 32'd1 == FRAME_TOTAL))
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            pop_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= next_state;
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
                pop_count  <= '0;
                overflow   <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) begin
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    pop_count <= pop_count + 32'd1;
                end
                if (push && !pop)
                    fill_level <= fill_level + FILL_ONE;
                else if (pop && !push)
                    fill_level <= fill_level - FILL_ONE;
                if (drop) overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers and fill count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst_in)
            mem[wr_ptr] <= {in_data, in_x, in_y, in_ch};
    end

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed bench for output_drain_buffer: expected entries are queued when
// issued and compared by an independent monitor when the DUT hands them out.
module tb_output_drain_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [31:0]   in_x = '0, in_y = '0, in_ch = '0;
    logic          stall, out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [31:0]   out_x, out_y, out_ch;
    logic [4:0]    fill_level;
    logic          overflow, done;
    logic [1:0]    state_dbg;

    logic [DW+95:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    output_drain_buffer #(
        .FIFO_DEPTH(DEPTH), .STALL_SLACK(5), .DATA_WIDTH(DW),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .fill_level(fill_level), .overflow(overflow), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_in && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got data=%0h x=%0d y=%0d ch=%0d, required no entry",
                         out_data, out_x, out_y, out_ch);
            end else begin
                logic [DW+95:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_x, out_y, out_ch} !== e) begin
                    errors++;
                    $display("FAIL pop_entry: got %h, required %h",
                             {out_data, out_x, out_y, out_ch}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_cycle(input int i, input bit accept);
        in_valid = 1'b1;
        in_data  = 32'hA000_0000 + 32'(i);
        in_x     = 32'(i);
        in_y     = 32'(i * 2);
        in_ch    = 32'(i * 3);
        if (accept) exp_q.push_back({in_data, in_x, in_y, in_ch});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        bit seen;

        tick();
        tick();
        check("rst_fill", 32'(fill_level), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(state_dbg), 0);
        rst_in = 1'b0;

        // single result, immediate drain
        out_ready = 1'b1;
        start_frame();
        check("t1_state_active", 32'(state_dbg), 1);
        in_valid = 1'b1; in_data = 32'h55; in_x = 1; in_y = 2; in_ch = 3;
        exp_q.push_back({in_data, in_x, in_y, in_ch});
        check("t1_no_bypass", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_fill_1", 32'(fill_level), 1);
        tick();
        check("t1_fill_0", 32'(fill_level), 0);
        check("t1_out_valid_0", 32'(out_valid), 0);

        // fill up, stall threshold, overflow
        out_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 10; i++) push_cycle(i, 1'b1);
        check("t2_fill_10", 32'(fill_level), 10);
        check("t2_stall_10", 32'(stall), 0);
        push_cycle(10, 1'b1);
        check("t2_fill_11", 32'(fill_level), 11);
        check("t2_stall_11", 32'(stall), 1);
        for (int i = 11; i < 16; i++) push_cycle(i, 1'b1);
        check("t2_fill_16", 32'(fill_level), 16);
        check("t2_overflow_pre", 32'(overflow), 0);
        push_cycle(16, 1'b0);
        check("t2_fill_16_drop", 32'(fill_level), 16);
        check("t2_overflow", 32'(overflow), 1);

        // full with simultaneous push/pop, order across wrap
        start_frame();
        check("t3_overflow_clr", 32'(overflow), 0);
        check("t3_fill_clr", 32'(fill_level), 0);
        for (int i = 0; i < 16; i++) push_cycle(100 + i, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cycle(200 + i, 1'b1);
            check("t3_fill_full", 32'(fill_level), 16);
            check("t3_overflow_0", 32'(overflow), 0);
        end
        for (int c = 0; c < 40 && fill_level != 0; c++) tick();
        check("t3_drained", 32'(fill_level), 0);
        check("t3_queue_empty", 32'(exp_q.size()), 0);
        out_ready = 1'b0;

        // 2x2x2 frame with random host readiness
        start_frame();
        done_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            push_cycle(300 + i, 1'b1);
            if (done) done_cnt++;
        end
        for (int c = 0; c < 200 && !seen; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) begin
                seen = 1'b1;
                done_cnt++;
                check("t4_state_done", 32'(state_dbg), 2);
                check("t4_fill_at_done", 32'(fill_level), 0);
            end
        end
        check("t4_done_seen", 32'(seen), 1);
        out_ready = 1'b0;
        tick();
        check("t4_state_idle", 32'(state_dbg), 0);
        for (int c = 0; c < 4; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("t4_done_once", 32'(done_cnt), 1);
        in_valid = 1'b1; in_data = 32'hDEAD; in_x = 9; in_y = 9; in_ch = 9;
        tick();
        in_valid = 1'b0;
        check("t4_idle_ignored", 32'(fill_level), 0);
        check("t4_idle_no_ovf", 32'(overflow), 0);

        // reset mid-frame, then start with overflow set
        start_frame();
        for (int i = 0; i < 5; i++) push_cycle(400 + i, 1'b1);
        check("t5_fill_5", 32'(fill_level), 5);
        rst_in = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        exp_q.delete();
        tick();
        rst_in = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check("t5_rst_fill", 32'(fill_level), 0);
        check("t5_rst_out_valid", 32'(out_valid), 0);
        check("t5_rst_state", 32'(state_dbg), 0);
        start_frame();
        for (int i = 0; i < 16; i++) push_cycle(500 + i, 1'b1);
        push_cycle(516, 1'b0);
        check("t5_overflow_set", 32'(overflow), 1);
        exp_q.delete();
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        check("t5_start_ovf_clr", 32'(overflow), 0);
        check("t5_start_fill", 32'(fill_level), 0);
        check("t5_start_state", 32'(state_dbg), 1);
        check("t5_start_out_valid", 32'(out_valid), 0);

        tick();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
